// File: rtl/boreal_ik_cmd_receiver.sv
// Receives clamped VM targets, queues them and feeds slew-limited set-points to the IK solver.
// Optional feature macro: BOREAL_IKRX_SLEW_EN (defined = per-beat slew limit, undefined = one beat per target).
module boreal_ik_cmd_receiver #(
    parameter int                 DEPTH     = 4,
    parameter logic signed [15:0] COORD_MIN = -16'sd1024,
    parameter logic signed [15:0] COORD_MAX = 16'sd1024,
    parameter int                 SLEW_MAX  = 32,
    parameter logic signed [15:0] HOME_X    = 16'sd0,
    parameter logic signed [15:0] HOME_Y    = 16'sd0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             safety_tier,
    input  logic                   vm_ik_enable,
    input  logic signed [15:0]     target_x,
    input  logic signed [15:0]     target_y,
    input  logic                   vm_vns_override,
    output logic signed [15:0]     ik_x,
    output logic signed [15:0]     ik_y,
    output logic                   ik_valid,
    input  logic                   ik_ready,
    output logic                   vns_req,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   clamp_flag,
    output logic [7:0]             overflow_cnt,
    output logic                   busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic signed [16:0] SLEW17 = 17'(SLEW_MAX);

    typedef enum logic [1:0] {S_IDLE, S_STEP, S_WAIT} state_t;

    function automatic logic out_of_range(input logic signed [15:0] v);
        return (v < COORD_MIN) || (v > COORD_MAX);
    endfunction

    function automatic logic signed [15:0] clamp_coord(input logic signed [15:0] v);
        if (v < COORD_MIN)
            return COORD_MIN;
        else if (v > COORD_MAX)
            return COORD_MAX;
        return v;
    endfunction

    // Difference taken in 17 bits so the full 16-bit span cannot wrap before clipping.
    function automatic logic signed [15:0] slew_step(input logic signed [15:0] cur,
                                                     input logic signed [15:0] goal);
        logic signed [16:0] d;
        d = $signed({goal[15], goal}) - $signed({cur[15], cur});
        if (d > SLEW17)
            d = SLEW17;
        else if (d < -SLEW17)
            d = -SLEW17;
        return 16'($signed({cur[15], cur}) + d);
    endfunction

    state_t             r_state;
    logic signed [15:0] r_ik_x, r_ik_y, r_cur_x, r_cur_y, r_goal_x, r_goal_y;
    logic               r_ik_valid, r_vns, r_clamp;
    logic [7:0]         r_ovf;
    logic [AW-1:0]      r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic signed [15:0] r_mem_x [DEPTH];
    logic signed [15:0] r_mem_y [DEPTH];

    logic               w_abort, w_full, w_empty, w_strobe_ok, w_push, w_pop, w_overflow;
    logic               w_at_goal, w_hs;
    logic signed [15:0] w_clamp_x, w_clamp_y, w_step_x, w_step_y;

    assign w_abort     = (safety_tier >= 2'd2);
    assign w_full      = (r_count == CW'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_strobe_ok = vm_ik_enable && !w_abort;
    assign w_pop       = (r_state == S_IDLE) && !w_empty && !w_abort;
    assign w_push      = w_strobe_ok && (!w_full || w_pop);
    assign w_overflow  = w_strobe_ok && w_full && !w_pop;
    assign w_clamp_x   = clamp_coord(target_x);
    assign w_clamp_y   = clamp_coord(target_y);
    assign w_at_goal   = (r_ik_x == r_goal_x) && (r_ik_y == r_goal_y);
    assign w_hs        = r_ik_valid && ik_ready;

    always_comb begin
`ifdef BOREAL_IKRX_SLEW_EN
        w_step_x = slew_step(r_cur_x, r_goal_x);
        w_step_y = slew_step(r_cur_y, r_goal_y);
`else
        w_step_x = r_goal_x;
        w_step_y = r_goal_y;
`endif
    end

    // Queue storage and goal latch carry data only, so they are left out of reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_x[r_wr_ptr] <= w_clamp_x;
            r_mem_y[r_wr_ptr] <= w_clamp_y;
        end
        if (w_pop) begin
            r_goal_x <= r_mem_x[r_rd_ptr];
            r_goal_y <= r_mem_y[r_rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ik_x     <= HOME_X;
            r_ik_y     <= HOME_Y;
            r_cur_x    <= HOME_X;
            r_cur_y    <= HOME_Y;
            r_ik_valid <= 1'b0;
            r_vns      <= 1'b0;
            r_clamp    <= 1'b0;
            r_ovf      <= 8'd0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_vns   <= vm_vns_override;
            r_clamp <= w_strobe_ok && (out_of_range(target_x) || out_of_range(target_y));
            if (w_overflow && (r_ovf != 8'hFF))
                r_ovf <= r_ovf + 8'd1;

            if (w_abort) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push)
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                if (w_pop)
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                if (w_push && !w_pop)
                    r_count <= r_count + CW'(1);
                else if (w_pop && !w_push)
                    r_count <= r_count - CW'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (w_pop)
                        r_state <= S_STEP;
                end
                S_STEP: begin
                    if (w_abort) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_ik_x     <= w_step_x;
                        r_ik_y     <= w_step_y;
                        r_ik_valid <= 1'b1;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A handshake coinciding with an abort still commits the set-point.
                    if (w_hs) begin
                        r_cur_x    <= r_ik_x;
                        r_cur_y    <= r_ik_y;
                        r_ik_valid <= 1'b0;
                        r_state    <= (w_abort || w_at_goal) ? S_IDLE : S_STEP;
                    end else if (w_abort) begin
                        r_ik_valid <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ik_x         = r_ik_x;
    assign ik_y         = r_ik_y;
    assign ik_valid     = r_ik_valid;
    assign vns_req      = r_vns;
    assign fifo_count   = r_count;
    assign clamp_flag   = r_clamp;
    assign overflow_cnt = r_ovf;
    assign busy         = (r_state != S_IDLE) || !w_empty;
endmodule

// File: tb/tb_boreal_ik_cmd_receiver.sv
// Self-checking bench for boreal_ik_cmd_receiver: vector table, directed corner sequences and a random run.
// Expected beats follow BOREAL_IKRX_SLEW_EN the same way the design does.
module tb_boreal_ik_cmd_receiver;
    localparam int DEPTH = 4;
    localparam int SLEW  = 32;
    localparam int CMIN  = -1024;
    localparam int CMAX  = 1024;
`ifdef BOREAL_IKRX_SLEW_EN
    localparam bit SLEW_ON = 1'b1;
`else
    localparam bit SLEW_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        safety_tier;
    logic              vm_ik_enable;
    logic signed [15:0] target_x, target_y;
    logic              vm_vns_override;
    logic signed [15:0] ik_x, ik_y;
    logic              ik_valid, ik_ready, vns_req;
    logic [2:0]        fifo_count;
    logic              clamp_flag;
    logic [7:0]        overflow_cnt;
    logic              busy;

    always #5 clk = ~clk;

    boreal_ik_cmd_receiver dut (
        .clk(clk), .rst(rst), .safety_tier(safety_tier), .vm_ik_enable(vm_ik_enable),
        .target_x(target_x), .target_y(target_y), .vm_vns_override(vm_vns_override),
        .ik_x(ik_x), .ik_y(ik_y), .ik_valid(ik_valid), .ik_ready(ik_ready),
        .vns_req(vns_req), .fifo_count(fifo_count), .clamp_flag(clamp_flag),
        .overflow_cnt(overflow_cnt), .busy(busy)
    );

    typedef struct { int x; int y; } pt_t;
    typedef struct { int tx; int ty; int clamp; int nb; int fx; int fy; int lx; int ly; } vec_t;

    int   tests = 0;
    int   fails = 0;
    pt_t  exp_q[$];
    int   mx, my;
    bit   mon_en = 1'b0;
    vec_t vecs[8];

    task automatic chk(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    function automatic int clampc(input int v);
        return (v < CMIN) ? CMIN : ((v > CMAX) ? CMAX : v);
    endfunction

    function automatic int toward(input int c, input int g);
        int d;
        d = g - c;
        if (SLEW_ON && d > SLEW)  d = SLEW;
        if (SLEW_ON && d < -SLEW) d = -SLEW;
        return c + d;
    endfunction

    // Reference: walk from the model position to the clamped goal, at least one beat.
    task automatic model_target(input int tx, input int ty);
        int  gx, gy;
        pt_t p;
        gx = clampc(tx);
        gy = clampc(ty);
        do begin
            mx = toward(mx, gx);
            my = toward(my, gy);
            p.x = mx;
            p.y = my;
            exp_q.push_back(p);
        end while (mx != gx || my != gy);
    endtask

    // Monitor: handshakes vs model queue, hold-while-stalled, vns delay, clamp pulse.
    bit  pv_pend = 1'b0, pv_vns = 1'b0, pv_clamp = 1'b0;
    int  pv_x = 0, pv_y = 0;
    pt_t me;
    always @(negedge clk) begin
        if (mon_en) begin
            if (pv_pend) begin
                chk("hold_valid", int'(ik_valid), 1);
                chk("hold_x", int'(ik_x), pv_x);
                chk("hold_y", int'(ik_y), pv_y);
            end
            chk("vns_req", int'(vns_req), int'(pv_vns));
            chk("clamp_flag", int'(clamp_flag), int'(pv_clamp));
            if (ik_valid && ik_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 1, 0);
                end else begin
                    me = exp_q.pop_front();
                    chk("beat_x", int'(ik_x), me.x);
                    chk("beat_y", int'(ik_y), me.y);
                end
            end
        end
        pv_pend  = ik_valid && !ik_ready && (safety_tier < 2'd2);
        pv_x     = int'(ik_x);
        pv_y     = int'(ik_y);
        pv_vns   = vm_vns_override;
        pv_clamp = vm_ik_enable && (safety_tier < 2'd2) &&
                   (int'(target_x) != clampc(int'(target_x)) || int'(target_y) != clampc(int'(target_y)));
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; vm_ik_enable = 1'b0; safety_tier = 2'b00;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic strobe(input int tx, input int ty);
        @(posedge clk); #1;
        vm_ik_enable = 1'b1; target_x = 16'(tx); target_y = 16'(ty);
        @(posedge clk); #1;
        vm_ik_enable = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!ik_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(ik_valid), 1);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy || ik_valid) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_left"}, exp_q.size(), 0);
        chk({name, "_busy"}, int'(busy), 0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int first_k = -1, nb = 0, fx = 0, fy = 0, lx = 0, ly = 0;
        bit done = 1'b0;
        do_reset();
        ik_ready = 1'b1;
        @(posedge clk); #1;
        vm_ik_enable = 1'b1; target_x = 16'(v.tx); target_y = 16'(v.ty);
        @(posedge clk); #1;
        vm_ik_enable = 1'b0;
        for (int k = 1; k <= 300 && !done; k++) begin
            @(negedge clk);
            if (k == 1) chk($sformatf("vec%0d_clamp", idx), int'(clamp_flag), v.clamp);
            if (k == 2) chk($sformatf("vec%0d_clamp_pulse", idx), int'(clamp_flag), 0);
            if (ik_valid) begin
                if (first_k < 0) begin
                    first_k = k; fx = int'(ik_x); fy = int'(ik_y);
                end
                nb++;
                lx = int'(ik_x); ly = int'(ik_y);
            end
            if (k > 3 && !busy && !ik_valid) done = 1'b1;
        end
        chk($sformatf("vec%0d_latency", idx), first_k, 3);
        chk($sformatf("vec%0d_beats", idx), nb, v.nb);
        chk($sformatf("vec%0d_first_x", idx), fx, v.fx);
        chk($sformatf("vec%0d_first_y", idx), fy, v.fy);
        chk($sformatf("vec%0d_last_x", idx), lx, v.lx);
        chk($sformatf("vec%0d_last_y", idx), ly, v.ly);
        chk($sformatf("vec%0d_idle", idx), int'(done), 1);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  hs, ax, ay, bad, sent, tx, ty, hx, hy;
        pt_t e;
        rst = 1'b1; safety_tier = 2'b00; vm_ik_enable = 1'b0; target_x = '0; target_y = '0;
        vm_vns_override = 1'b0; ik_ready = 1'b0;

        // {tx, ty, clamp, beats, first x/y, last x/y}
        if (SLEW_ON) begin
            vecs[0] = '{120, 120, 0, 4, 32, 32, 120, 120};
            vecs[1] = '{2000, -3000, 1, 32, 32, -32, 1024, -1024};
            vecs[2] = '{0, 0, 0, 1, 0, 0, 0, 0};
            vecs[3] = '{-100, 50, 0, 4, -32, 32, -100, 50};
            vecs[4] = '{1024, -1024, 0, 32, 32, -32, 1024, -1024};
            vecs[5] = '{-32768, 32767, 1, 32, -32, 32, -1024, 1024};
            vecs[6] = '{1025, -1025, 1, 32, 32, -32, 1024, -1024};
            vecs[7] = '{120, -50, 0, 4, 32, -32, 120, -50};
        end else begin
            vecs[0] = '{120, 120, 0, 1, 120, 120, 120, 120};
            vecs[1] = '{2000, -3000, 1, 1, 1024, -1024, 1024, -1024};
            vecs[2] = '{0, 0, 0, 1, 0, 0, 0, 0};
            vecs[3] = '{-100, 50, 0, 1, -100, 50, -100, 50};
            vecs[4] = '{1024, -1024, 0, 1, 1024, -1024, 1024, -1024};
            vecs[5] = '{-32768, 32767, 1, 1, -1024, 1024, -1024, 1024};
            vecs[6] = '{1025, -1025, 1, 1, 1024, -1024, 1024, -1024};
            vecs[7] = '{120, -50, 0, 1, 120, -50, 120, -50};
        end

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ik_x", int'(ik_x), 0);
        chk("rst_ik_y", int'(ik_y), 0);
        chk("rst_valid", int'(ik_valid), 0);
        chk("rst_vns", int'(vns_req), 0);
        chk("rst_count", int'(fifo_count), 0);
        chk("rst_clamp", int'(clamp_flag), 0);
        chk("rst_ovf", int'(overflow_cnt), 0);
        chk("rst_busy", int'(busy), 0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Overflow: six back-to-back strobes with the IK stalled, the sixth is dropped.
        do_reset();
        ik_ready = 1'b0; mx = 0; my = 0; exp_q.delete(); mon_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            tx = (i == 5) ? 999 : 10 * (i + 1);
            ty = (i == 5) ? 999 : -5 * (i + 1);
            vm_ik_enable = 1'b1; target_x = 16'(tx); target_y = 16'(ty);
            if (i < 5) model_target(tx, ty);
        end
        @(posedge clk); #1;
        vm_ik_enable = 1'b0;
        chk("ovf_count", int'(fifo_count), 4);
        chk("ovf_cnt", int'(overflow_cnt), 1);
        ik_ready = 1'b1;
        wait_drain("ovf_drain");
        mon_en = 1'b0;

        // Overflow counter saturates.
        do_reset();
        ik_ready = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            vm_ik_enable = 1'b1; target_x = 16'sd1; target_y = 16'sd1;
        end
        @(posedge clk); #1;
        vm_ik_enable = 1'b0;
        @(negedge clk);
        chk("ovf_sat", int'(overflow_cnt), 255);
        chk("ovf_sat_count", int'(fifo_count), 4);

        // Abort while a beat is pending without ready: valid withdrawn, queue flushed.
        do_reset();
        ik_ready = 1'b0;
        @(posedge clk); #1;
        vm_ik_enable = 1'b1; target_x = 16'sd100; target_y = -16'sd100;
        @(posedge clk); #1;
        target_x = 16'sd7; target_y = 16'sd7;
        @(posedge clk); #1;
        vm_ik_enable = 1'b0;
        wait_valid("abortA_valid");
        hx = int'(ik_x); hy = int'(ik_y);
        chk("abortA_pending", int'(fifo_count), 1);
        @(posedge clk); #1 safety_tier = 2'b11;
        @(posedge clk); #1 safety_tier = 2'b00;
        @(negedge clk);
        chk("abortA_valid_drop", int'(ik_valid), 0);
        chk("abortA_flush", int'(fifo_count), 0);
        chk("abortA_busy", int'(busy), 0);
        chk("abortA_hold_x", int'(ik_x), hx);
        chk("abortA_hold_y", int'(ik_y), hy);
        ik_ready = 1'b1; bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (ik_valid) bad++;
        end
        chk("abortA_no_beat", bad, 0);
        exp_q.delete(); mx = 0; my = 0; model_target(-40, 0);
        mon_en = 1'b1;
        strobe(-40, 0);
        wait_drain("abortA_resume");
        mon_en = 1'b0;

        // Abort mid-motion after a beat was accepted: resume from the accepted point.
        do_reset();
        ik_ready = 1'b1; exp_q.delete(); mx = 0; my = 0;
        model_target(120, 120);
        e = exp_q[SLEW_ON ? 1 : 0];
        strobe(120, 120);
        hs = 0; ax = 0; ay = 0;
        for (int k = 0; k < 40 && hs < (SLEW_ON ? 2 : 1); k++) begin
            @(negedge clk);
            if (ik_valid && ik_ready) begin
                hs++; ax = int'(ik_x); ay = int'(ik_y);
            end
        end
        chk("abortB_hs", hs, SLEW_ON ? 2 : 1);
        chk("abortB_acc_x", ax, e.x);
        chk("abortB_acc_y", ay, e.y);
        @(posedge clk); #1 safety_tier = 2'b10;
        @(posedge clk); #1 safety_tier = 2'b00;
        @(negedge clk);
        chk("abortB_valid", int'(ik_valid), 0);
        chk("abortB_flush", int'(fifo_count), 0);
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (ik_valid || busy) bad++;
        end
        chk("abortB_quiet", bad, 0);
        exp_q.delete(); mx = e.x; my = e.y; model_target(0, 0);
        mon_en = 1'b1;
        strobe(0, 0);
        wait_drain("abortB_resume");
        mon_en = 1'b0;

        // Stall: ready low for 10 cycles, beat held, then one handshake.
        do_reset();
        ik_ready = 1'b0; exp_q.delete(); mx = 0; my = 0; model_target(50, 60);
        mon_en = 1'b1;
        strobe(50, 60);
        wait_valid("stall_valid");
        hx = int'(ik_x); hy = int'(ik_y); bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (!ik_valid || int'(ik_x) != hx || int'(ik_y) != hy) bad++;
        end
        chk("stall_hold", bad, 0);
        @(posedge clk); #1 ik_ready = 1'b1;
        @(negedge clk);
        chk("stall_hs", int'(ik_valid), 1);
        @(negedge clk);
        chk("stall_once", int'(ik_valid), 0);
        wait_drain("stall_drain");
        mon_en = 1'b0;

        // Reset mid-transfer after an accepted beat: position returns home.
        do_reset();
        ik_ready = 1'b1;
        strobe(120, 120);
        hs = 0;
        for (int k = 0; k < 20 && hs == 0; k++) begin
            @(negedge clk);
            if (ik_valid && ik_ready) hs = 1;
        end
        chk("rstmid_hs", hs, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_ik_x", int'(ik_x), 0);
        chk("rstmid_ik_y", int'(ik_y), 0);
        chk("rstmid_valid", int'(ik_valid), 0);
        chk("rstmid_busy", int'(busy), 0);
        exp_q.delete(); mx = 0; my = 0; model_target(-40, 0);
        mon_en = 1'b1;
        strobe(-40, 0);
        wait_drain("rstmid_resume");
        mon_en = 1'b0;

        // Random targets, random ready and override, strobes only when the queue has room.
        do_reset();
        exp_q.delete(); mx = 0; my = 0; sent = 0; mon_en = 1'b1;
        for (int c = 0; c < 20000 && (sent < 40 || exp_q.size() != 0 || busy); c++) begin
            @(posedge clk); #1;
            ik_ready = ($urandom_range(3) != 0);
            vm_vns_override = 1'($urandom_range(1));
            if (sent < 40 && $urandom_range(2) == 0 && int'(fifo_count) < DEPTH) begin
                tx = int'($urandom_range(3000)) - 1500;
                ty = int'($urandom_range(3000)) - 1500;
                vm_ik_enable = 1'b1; target_x = 16'(tx); target_y = 16'(ty);
                model_target(tx, ty);
                sent++;
            end else begin
                vm_ik_enable = 1'b0;
            end
        end
        vm_ik_enable = 1'b0;
        @(negedge clk);
        mon_en = 1'b0;
        chk("rand_sent", sent, 40);
        chk("rand_left", exp_q.size(), 0);
        chk("rand_busy", int'(busy), 0);
        chk("rand_ovf", int'(overflow_cnt), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/boreal_ik_cmd_receiver.md
Name: boreal_ik_cmd_receiver

Overview:
Receiving end of the decision-VM → IK target interface. It captures each (target_x, target_y) pair on the VM's one-cycle enable strobe and range-clamps it. It buffers the pairs in a small FIFO and hands the CORDIC IK solver a slew-limited stream of intermediate set-points over a valid/ready handshake. Safety tiers T2/T3 flush all pending motion.

Parameters:
DEPTH, 4, FIFO entries (power of two, ≥2)
COORD_MIN, -1024, signed 16-bit lower clamp applied to both axes
COORD_MAX, 1024, signed 16-bit upper clamp applied to both axes
SLEW_MAX, 32, max per-beat |Δ| per axis (positive, ≤ COORD_MAX-COORD_MIN)
HOME_X, 0, reset position X
HOME_Y, 0, reset position Y

Ports:
clk  in  1  single clock, all logic rising-edge
rst  in  1  synchronous, active-high reset
safety_tier  in  2  00/01 run; 10/11 freeze+flush
vm_ik_enable  in  1  one-cycle strobe, target valid
target_x  in  16  signed goal X
target_y  in  16  signed goal Y
vm_vns_override  in  1  VNS override request, pass-through
ik_x  out  16  signed set-point X to IK
ik_y  out  16  signed set-point Y to IK
ik_valid  out  1  set-point valid
ik_ready  in  1  IK accepts set-point
vns_req  out  1  registered copy of vm_vns_override
fifo_count  out  3  entries held, 0..DEPTH (width clog2(DEPTH)+1)
clamp_flag  out  1  one-cycle pulse, captured target was clamped
overflow_cnt  out  8  saturating count of dropped strobes
busy  out  1  FSM not IDLE or FIFO non-empty

Behaviour:
- Interface decision: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset values: ik_x=HOME_X, ik_y=HOME_Y, ik_valid=0, vns_req=0, fifo_count=0, clamp_flag=0, overflow_cnt=0, busy=0. Internal cur_x/cur_y = HOME, FSM=IDLE, FIFO pointers zero.
- Capture: on vm_ik_enable=1 with tier<2:
  - Clamp each axis to [COORD_MIN, COORD_MAX] using a signed compare.
  - clamp_flag pulses next cycle if either axis was clamped.
  - Push the clamped pair.
- Overflow: strobe while full and no pop that same cycle → pair dropped, overflow_cnt+1, saturating at 255. Push and pop in the same cycle while full → push accepted.
- Tier block at capture: strobe with tier≥2 → dropped silently; not counted as overflow.
- FSM IDLE: if FIFO non-empty and tier<2 → pop head into goal_x/goal_y, go to STEP.
- FSM STEP:
  - Per axis: d = goal − cur, computed in 17 bits. Clip d to ±SLEW_MAX.
  - ik_x/ik_y <= cur + clipped d.
  - ik_valid <= 1, go to WAIT.
- FSM WAIT:
  - While ik_ready=0: ik_x, ik_y and ik_valid hold stable.
  - On ik_valid&&ik_ready: cur <= ik_x/ik_y and ik_valid <= 0.
  - Then, if ik_x==goal_x and ik_y==goal_y → IDLE; otherwise → STEP.
- Latency: strobe in cycle N → first ik_valid high in cycle N+3, given an empty FIFO and FSM in IDLE. Each intermediate beat takes 2 cycles once ready is held high.
- Goal equal to cur: a single beat is still issued, carrying the unchanged position.
- Safety abort: tier≥2 on any cycle →
  - FIFO flushed (count 0) next cycle.
  - FSM → IDLE; ik_valid → 0 next cycle, even without ready. This is the only permitted withdrawal of valid.
  - cur keeps the last accepted set-point; ik_x/ik_y hold their value.
- Simultaneous tier≥2 and ik_ready handshake: the handshake completes (cur updates), then the abort takes effect.
- vns_req = vm_vns_override delayed by 1 cycle. It does not affect motion.
- busy = (FSM≠IDLE) || (fifo_count≠0).
- rst mid-transfer: everything returns to reset values next cycle, including cur=HOME.

Optional Feature:
Macro BOREAL_IKRX_SLEW_EN.
- Defined: slew limiting exactly as above.
- Undefined: STEP loads goal directly into ik_x/ik_y, so each FIFO entry produces exactly one beat. SLEW_MAX is ignored and all other behaviour is unchanged.

Test Plan:
1. Reset, ik_ready=1, strobe (120,120) → beats (32,32),(64,64),(96,96),(120,120). First ik_valid 3 cycles after the strobe; busy drops after the last beat.
2. Strobe (2000,-3000) → clamp_flag pulse 1 cycle later. Final beat is (1024,-1024); first beat is (32,-32).
3. ik_ready=0, 6 strobes back-to-back → first pair popped, fifo_count=4, overflow_cnt=1. Dropped pair never appears.
4. Mid-motion toward (120,120) after beat (64,64) accepted, tier=2'b10 for 1 cycle → ik_valid 0 next cycle, fifo_count=0. Tier back to 00, strobe (0,0) → beats start from (64,64): (32,32),(0,0).
5. ik_ready held 0 for 10 cycles during a beat → ik_x/ik_y/ik_valid stable. Ready 1 → exactly one handshake.
6. BOREAL_IKRX_SLEW_EN undefined, strobe (120,-50) → single beat (120,-50), ik_valid at N+3.
